// File: rtl/tetris_timer_if.sv
// Avalon-MM bundle between the timer controller (master) and the tetris_timer slave.
interface tetris_timer_if;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 16;

    logic [ADDR_W-1:0] tm_address;
    logic              tm_chipselect;
    logic              tm_write_n;
    logic [DATA_W-1:0] tm_writedata;
    logic [DATA_W-1:0] tm_readdata;
    logic              tm_irq;

    modport master (
        output tm_address, tm_chipselect, tm_write_n, tm_writedata,
        input  tm_readdata, tm_irq
    );

    modport slave (
        input  tm_address, tm_chipselect, tm_write_n, tm_writedata,
        output tm_readdata, tm_irq
    );
endinterface

// File: rtl/tetris_timer_ctrl.sv
// Controller that initialises the tetris_timer slave, services its irq into gravity ticks,
// reprograms the period on demand and reads back 32-bit counter snapshots.
module tetris_timer_ctrl #(
    parameter logic [31:0] DEFAULT_PERIOD = 32'd49999,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    tetris_timer_if.master        tm,
    input  logic [31:0]           period_in,
    input  logic                  period_load,
    input  logic                  run_en,
    input  logic                  snap_req,
    output logic                  tick,
    output logic [15:0]           tick_count,
    output logic [31:0]           snap_value,
    output logic                  snap_valid,
    output logic                  busy
);
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 16;
    localparam logic [DATA_W-1:0] CTRL_START = 16'h0007;
    localparam logic [DATA_W-1:0] CTRL_STOP  = 16'h000B;

    typedef enum logic [3:0] {
        IDLE, INIT_PL, INIT_PH, INIT_CTRL, ACK, GUARD, LOAD_L, LOAD_H,
        CTRL, SNAP_W, SNAP_RL, SNAP_RH, SNAP_DONE
    } state_t;

    state_t              state, state_d;
    logic                cs_q, cs_d;
    logic                wn_q, wn_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wd_q, wd_d;
    logic                tick_d;
    logic                running, running_d;
    logic                pend_period, pend_snap;
    logic [31:0]         period_q;
    logic [DATA_W-1:0]   snap_lo;

    assign tm.tm_chipselect = cs_q;
    assign tm.tm_write_n    = wn_q;
    assign tm.tm_address    = addr_q;
    assign tm.tm_writedata  = wd_q;

    // Bus outputs are registered from the access belonging to the next state.
    // INIT_PL is held one extra cycle after reset so its write is issued from an idle bus.
    always_comb begin
        state_d   = state;
        cs_d      = 1'b0;
        wn_d      = 1'b1;
        addr_d    = '0;
        wd_d      = '0;
        running_d = running;

        case (state)
            INIT_PL:   state_d = cs_q ? INIT_PH : INIT_PL;
            INIT_PH:   state_d = INIT_CTRL;
            INIT_CTRL: state_d = IDLE;
            IDLE: begin
                if (tm.tm_irq)                state_d = ACK;
                else if (pend_period)         state_d = LOAD_L;
                else if (run_en != running)   state_d = CTRL;
                else if (pend_snap)           state_d = SNAP_W;
            end
            ACK:       state_d = GUARD;
            GUARD:     state_d = IDLE;
            LOAD_L:    state_d = LOAD_H;
            LOAD_H:    state_d = CTRL;
            CTRL:      state_d = IDLE;
            SNAP_W:    state_d = SNAP_RL;
            SNAP_RL:   state_d = SNAP_RH;
            SNAP_RH:   state_d = SNAP_DONE;
            SNAP_DONE: state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        case (state_d)
            INIT_PL, LOAD_L: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_W'(2); wd_d = period_q[15:0];
            end
            INIT_PH, LOAD_H: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_W'(3); wd_d = period_q[31:16];
            end
            INIT_CTRL: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_W'(1);
                wd_d = (AUTO_START && run_en) ? CTRL_START : CTRL_STOP;
                running_d = AUTO_START && run_en;
            end
            CTRL: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_W'(1);
                wd_d = run_en ? CTRL_START : CTRL_STOP;
                running_d = run_en;
            end
            ACK: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_W'(0);
            end
            SNAP_W: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_W'(4);
            end
            SNAP_RL: begin
                cs_d = 1'b1; addr_d = ADDR_W'(4);
            end
            SNAP_RH: begin
                cs_d = 1'b1; addr_d = ADDR_W'(5);
            end
            default: ;
        endcase

        // A stale irq (timer stopped) is acknowledged but produces no tick.
        tick_d = (state_d == ACK) && running;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= INIT_PL;
            cs_q        <= 1'b0;
            wn_q        <= 1'b1;
            addr_q      <= '0;
            wd_q        <= '0;
            tick        <= 1'b0;
            tick_count  <= '0;
            busy        <= 1'b0;
            running     <= 1'b0;
            pend_period <= 1'b0;
            pend_snap   <= 1'b0;
            period_q    <= DEFAULT_PERIOD;
            snap_lo     <= '0;
            snap_value  <= '0;
            snap_valid  <= 1'b0;
        end else begin
            state   <= state_d;
            cs_q    <= cs_d;
            wn_q    <= wn_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            tick    <= tick_d;
            busy    <= (state_d != IDLE);
            running <= running_d;
            if (tick_d)
                tick_count <= tick_count + 16'd1;

            // Zero would pin the slave counter, so it is latched as one.
            if (period_load)
                period_q <= (period_in == 32'd0) ? 32'd1 : period_in;
            pend_period <= period_load || (pend_period && (state_d != LOAD_L));
            pend_snap   <= snap_req    || (pend_snap   && (state_d != SNAP_W));

            // Read data lags the presented address by one cycle.
            if (state == SNAP_RH)
                snap_lo <= tm.tm_readdata;
            snap_valid <= (state == SNAP_DONE);
            if (state == SNAP_DONE)
                snap_value <= {tm.tm_readdata, snap_lo};
        end
    end
endmodule

// File: tb/tb_tetris_timer_ctrl.sv
// Bench for tetris_timer_ctrl: slave model, bus-access scoreboard, tick/snapshot pulse monitors.
module tb_tetris_timer_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] period_in;
    logic        period_load;
    logic        run_en;
    logic        snap_req;
    logic        tick;
    logic [15:0] tick_count;
    logic [31:0] snap_value;
    logic        snap_valid;
    logic        busy;

    always #5 clk = ~clk;

    tetris_timer_if tm();

    tetris_timer_ctrl #(.DEFAULT_PERIOD(32'd49999), .AUTO_START(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .tm(tm),
        .period_in(period_in), .period_load(period_load), .run_en(run_en),
        .snap_req(snap_req), .tick(tick), .tick_count(tick_count),
        .snap_value(snap_value), .snap_valid(snap_valid), .busy(busy)
    );

    // Slave model: status set by fire_req, cleared by write to a0, irq is registered status.
    logic        status;
    logic        fire_req;
    logic [15:0] snap_lo_m, snap_hi_m;
    always @(posedge clk) begin
        if (!reset_n) begin
            status         <= 1'b0;
            tm.tm_irq      <= 1'b0;
            tm.tm_readdata <= 16'h0;
        end else begin
            if (tm.tm_chipselect && !tm.tm_write_n && tm.tm_address == 3'd0) status <= 1'b0;
            else if (fire_req) status <= 1'b1;
            tm.tm_irq <= status;
            if (tm.tm_chipselect && tm.tm_write_n)
                tm.tm_readdata <= (tm.tm_address == 3'd4) ? snap_lo_m :
                                  (tm.tm_address == 3'd5) ? snap_hi_m : 16'h0;
            else
                tm.tm_readdata <= 16'h0;
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  addr;
        logic [15:0] data;
        int          cyc;
    } acc_t;

    acc_t exp_q[$];
    acc_t obs_q[$];
    int   obs_rd = 0;

    int   cyc = 0;
    int   tick_pulses = 0, snap_pulses = 0;
    int   tick_cyc = 0, irq_cyc = 0;
    bit   tick_wide = 1'b0, snap_wide = 1'b0;
    logic tick_prev = 1'b0, snap_prev = 1'b0, irq_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tm.tm_chipselect)
            obs_q.push_back('{!tm.tm_write_n, tm.tm_address, tm.tm_writedata, cyc});
        if (tick) begin
            tick_pulses <= tick_pulses + 1;
            tick_cyc    <= cyc;
            if (tick_prev) tick_wide <= 1'b1;
        end
        if (snap_valid) begin
            snap_pulses <= snap_pulses + 1;
            if (snap_prev) snap_wide <= 1'b1;
        end
        if (tm.tm_irq && !irq_prev) irq_cyc <= cyc;
        tick_prev <= tick;
        snap_prev <= snap_valid;
        irq_prev  <= tm.tm_irq;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic expect_acc(input logic we, input logic [2:0] a, input logic [15:0] d);
        acc_t e;
        e.we = we; e.addr = a; e.data = d; e.cyc = 0;
        exp_q.push_back(e);
    endtask

    // Pop expected accesses against observed ones; optionally require back-to-back cycles.
    task automatic drain(input string name, input bit consec);
        int   idx = 0;
        int   first = 0;
        acc_t e, o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_rd >= obs_q.size()) begin
                checks++; errors++;
                $display("FAIL %s_missing: got none expected we=%0d a=%0d d=%h", name, e.we, e.addr, e.data);
            end else begin
                o = obs_q[obs_rd];
                obs_rd++;
                if (idx == 0) first = o.cyc;
                check({name, "_acc"}, 32'({o.we, o.addr, o.data}), 32'({e.we, e.addr, e.data}));
                if (consec && idx > 0) check({name, "_consec"}, 32'(o.cyc), 32'(first + idx));
            end
            idx++;
        end
        while (obs_rd < obs_q.size()) begin
            o = obs_q[obs_rd];
            obs_rd++;
            checks++; errors++;
            $display("FAIL %s_extra: got we=%0d a=%0d d=%h expected none", name, o.we, o.addr, o.data);
        end
    endtask

    task automatic wait_idle(input string name);
        int quiet = 0;
        int n = 0;
        repeat (4) @(negedge clk);
        while (quiet < 3 && n < 200) begin
            if (!busy) quiet++; else quiet = 0;
            n++;
            @(negedge clk);
        end
        check({name, "_idle"}, 32'(quiet >= 3), 32'd1);
    endtask

    task automatic pulse_load(input logic [31:0] p);
        @(negedge clk); period_in = p; period_load = 1'b1;
        @(negedge clk); period_load = 1'b0;
    endtask

    task automatic pulse_snap();
        @(negedge clk); snap_req = 1'b1;
        @(negedge clk); snap_req = 1'b0;
    endtask

    task automatic fire_irq();
        @(negedge clk); fire_req = 1'b1;
        @(negedge clk); fire_req = 1'b0;
    endtask

    typedef struct {
        logic [31:0] period;
        logic [15:0] lo;
        logic [15:0] hi;
    } pvec_t;

    typedef struct {
        logic [15:0] lo;
        logic [15:0] hi;
        logic [31:0] value;
    } svec_t;

    pvec_t pv[4];
    svec_t sv[2];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, s0, n;

        pv[0] = '{32'h0001_86A0, 16'h86A0, 16'h0001};
        pv[1] = '{32'h0000_0000, 16'h0001, 16'h0000};
        pv[2] = '{32'hDEAD_BEEF, 16'hBEEF, 16'hDEAD};
        pv[3] = '{32'h0000_0001, 16'h0001, 16'h0000};
        sv[0] = '{16'h1234, 16'h0000, 32'h0000_1234};
        sv[1] = '{16'hBEEF, 16'hCAFE, 32'hCAFE_BEEF};

        reset_n = 1'b0; run_en = 1'b1; period_in = '0; period_load = 1'b0;
        snap_req = 1'b0; fire_req = 1'b0; snap_lo_m = '0; snap_hi_m = '0;
        repeat (3) @(negedge clk);
        check("rst_cs", 32'(tm.tm_chipselect), 32'd0);
        check("rst_write_n", 32'(tm.tm_write_n), 32'd1);
        check("rst_addr_data", 32'({tm.tm_address, tm.tm_writedata}), 32'd0);
        check("rst_tick_busy", 32'({tick, busy, snap_valid}), 32'd0);
        check("rst_count_snap", 32'(tick_count) | snap_value, 32'd0);

        // Init sequence after release
        expect_acc(1'b1, 3'd2, 16'hC34F);
        expect_acc(1'b1, 3'd3, 16'h0000);
        expect_acc(1'b1, 3'd1, 16'h0007);
        reset_n = 1'b1;
        wait_idle("init");
        drain("init", 1'b1);
        check("init_busy", 32'(busy), 32'd0);

        // Timer irq -> one tick, one ack
        t0 = tick_pulses;
        expect_acc(1'b1, 3'd0, 16'h0000);
        fire_irq();
        wait_idle("irq");
        drain("irq", 1'b0);
        check("irq_ticks", 32'(tick_pulses - t0), 32'd1);
        check("irq_tick_wide", 32'(tick_wide), 32'd0);
        check("irq_latency", 32'(tick_cyc), 32'(irq_cyc + 1));
        check("irq_count", 32'(tick_count), 32'd1);

        // Period reprogramming table
        for (int i = 0; i < 4; i++) begin
            expect_acc(1'b1, 3'd2, pv[i].lo);
            expect_acc(1'b1, 3'd3, pv[i].hi);
            expect_acc(1'b1, 3'd1, 16'h0007);
            pulse_load(pv[i].period);
            wait_idle($sformatf("load%0d", i));
            drain($sformatf("load%0d", i), 1'b1);
        end
        check("load_count", 32'(tick_count), 32'd1);

        // Snapshot table
        for (int i = 0; i < 2; i++) begin
            s0 = snap_pulses;
            snap_lo_m = sv[i].lo; snap_hi_m = sv[i].hi;
            expect_acc(1'b1, 3'd4, 16'h0000);
            expect_acc(1'b0, 3'd4, 16'h0000);
            expect_acc(1'b0, 3'd5, 16'h0000);
            pulse_snap();
            wait_idle($sformatf("snap%0d", i));
            drain($sformatf("snap%0d", i), 1'b1);
            check($sformatf("snap%0d_value", i), snap_value, sv[i].value);
            check($sformatf("snap%0d_pulses", i), 32'(snap_pulses - s0), 32'd1);
        end
        check("snap_wide", 32'(snap_wide), 32'd0);

        // irq arriving mid-snapshot is acked only after the snapshot completes
        t0 = tick_pulses;
        snap_lo_m = 16'h5A5A; snap_hi_m = 16'h0001;
        expect_acc(1'b1, 3'd4, 16'h0000);
        expect_acc(1'b0, 3'd4, 16'h0000);
        expect_acc(1'b0, 3'd5, 16'h0000);
        expect_acc(1'b1, 3'd0, 16'h0000);
        @(negedge clk); snap_req = 1'b1; fire_req = 1'b1;
        @(negedge clk); snap_req = 1'b0; fire_req = 1'b0;
        wait_idle("snapirq");
        drain("snapirq", 1'b0);
        check("snapirq_value", snap_value, 32'h0001_5A5A);
        check("snapirq_ticks", 32'(tick_pulses - t0), 32'd1);
        check("snapirq_count", 32'(tick_count), 32'd2);

        // Stop, then a stale irq is acked without tick
        expect_acc(1'b1, 3'd1, 16'h000B);
        @(negedge clk); run_en = 1'b0;
        wait_idle("stop");
        drain("stop", 1'b0);
        t0 = tick_pulses;
        expect_acc(1'b1, 3'd0, 16'h0000);
        fire_irq();
        wait_idle("stale");
        drain("stale", 1'b0);
        check("stale_ticks", 32'(tick_pulses - t0), 32'd0);
        check("stale_count", 32'(tick_count), 32'd2);
        expect_acc(1'b1, 3'd1, 16'h0007);
        @(negedge clk); run_en = 1'b1;
        wait_idle("restart");
        drain("restart", 1'b0);

        // Reset during LOAD_H aborts and replays init
        expect_acc(1'b1, 3'd2, 16'h0000);
        expect_acc(1'b1, 3'd3, 16'h0002);
        @(negedge clk); period_in = 32'h0002_0000; period_load = 1'b1;
        @(negedge clk); period_load = 1'b0;
        n = 0;
        while (!(tm.tm_chipselect && tm.tm_address == 3'd3) && n < 20) begin
            @(negedge clk); n++;
        end
        check("abort_found_loadh", 32'(n < 20), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_bus_idle", 32'({tm.tm_chipselect, tm.tm_write_n}), 32'd1);
        check("abort_count", 32'(tick_count), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        drain("abort", 1'b1);
        expect_acc(1'b1, 3'd2, 16'hC34F);
        expect_acc(1'b1, 3'd3, 16'h0000);
        expect_acc(1'b1, 3'd1, 16'h0007);
        @(negedge clk); reset_n = 1'b1;
        wait_idle("reinit");
        drain("reinit", 1'b1);
        check("reinit_count", 32'(tick_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
